// File: rtl/writeback_stage_ctrl_if.sv
// MEM/WB operand bus, load-return channel and register-file write port
// of the MIPS write-back stage.
interface writeback_stage_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              MEM_Valid;
  logic              MEM_RegWrite;
  logic [REG_AW-1:0] MEM_WriteReg;
  logic [1:0]        MEM_WBSel;
  logic [2:0]        MEM_LoadType;
  logic [DATA_W-1:0] MEM_ALUResult;
  logic [DATA_W-1:0] MEM_LinkAddr;
  logic [DATA_W-1:0] MEM_HiLo;
  logic [DATA_W-1:0] LD_Data;
  logic              LD_Valid;
  logic              WB_Stall;
  logic              WB_Valid;
  logic              WB_RegWrite;
  logic [REG_AW-1:0] WB_WriteReg;
  logic [DATA_W-1:0] WB_WriteData;

  modport master (
    output MEM_Valid, MEM_RegWrite, MEM_WriteReg, MEM_WBSel,
    output MEM_LoadType, MEM_ALUResult, MEM_LinkAddr, MEM_HiLo,
    output LD_Data, LD_Valid,
    input  WB_Stall, WB_Valid, WB_RegWrite, WB_WriteReg, WB_WriteData
  );

  modport slave (
    input  MEM_Valid, MEM_RegWrite, MEM_WriteReg, MEM_WBSel,
    input  MEM_LoadType, MEM_ALUResult, MEM_LinkAddr, MEM_HiLo,
    input  LD_Data, LD_Valid,
    output WB_Stall, WB_Valid, WB_RegWrite, WB_WriteReg, WB_WriteData
  );
endinterface

// File: rtl/writeback_stage_ctrl.sv
// Registered MIPS write-back stage: result mux, load extension,
// and MEM stall while a multi-cycle load is outstanding.
module writeback_stage_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter bit ZERO_GUARD = 1'b1
) (
  input logic Clk,
  input logic Reset,
  writeback_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    WRITE,
    LWAIT
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  state_t            state;
  state_t            state_nxt;
  logic              capture;
  logic              rw_q;
  logic [REG_AW-1:0] reg_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        ltype_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              rw_in;

  assign capture = bus.MEM_Valid && (state != LWAIT);

  // write to r0 is dropped here so the register file needs no guard
  assign rw_in = bus.MEM_RegWrite &&
    !(ZERO_GUARD && (bus.MEM_WriteReg == '0));

  always_comb begin
    src = bus.MEM_ALUResult;
    unique case (bus.MEM_WBSel)
      SEL_ALU:  src = bus.MEM_ALUResult;
      SEL_LOAD: src = '0;
      SEL_LINK: src = bus.MEM_LinkAddr;
      default:  src = bus.MEM_HiLo;
    endcase
  end

  assign ld_byte = bus.LD_Data[8*off_q +: 8];
  assign ld_half = bus.LD_Data[16*off_q[1] +: 16];

  always_comb begin
    ld_ext = bus.LD_Data;
    unique case (ltype_q)
      LT_LH:   ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LT_LHU:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      LT_LB:   ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LT_LBU:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      default: ld_ext = bus.LD_Data;
    endcase
  end

  always_comb begin
    state_nxt = EMPTY;
    unique case (state)
      LWAIT:
        state_nxt = bus.LD_Valid ? WRITE : LWAIT;
      default:
        if (capture)
          state_nxt = (bus.MEM_WBSel == SEL_LOAD) ? LWAIT : WRITE;
        else
          state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= EMPTY;
      rw_q    <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      ltype_q <= '0;
      off_q   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rw_q    <= rw_in;
        reg_q   <= bus.MEM_WriteReg;
        data_q  <= src;
        ltype_q <= bus.MEM_LoadType;
        off_q   <= bus.MEM_ALUResult[1:0];
      end else if (state == LWAIT && bus.LD_Valid) begin
        data_q <= ld_ext;
      end
    end
  end

  assign bus.WB_Stall     = (state == LWAIT);
  assign bus.WB_Valid     = (state == WRITE);
  assign bus.WB_RegWrite  = (state == WRITE) && rw_q;
  assign bus.WB_WriteReg  = (state == WRITE) ? reg_q : '0;
  assign bus.WB_WriteData = (state == WRITE) ? data_q : '0;

endmodule

// File: tb/tb_writeback_stage_ctrl.sv
// Directed bench for writeback_stage_ctrl: reset, ALU stream,
// load extension, slow memory, r0 guard and reset during a load.
module tb_writeback_stage_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;

  writeback_stage_ctrl_if #(.DATA_W(32), .REG_AW(5)) bus ();

  writeback_stage_ctrl #(
    .DATA_W(32), .REG_AW(5), .ZERO_GUARD(1'b1)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [2:0] lt,
                       input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu);
    bus.MEM_Valid     = 1'b1;
    bus.MEM_WBSel     = sel;
    bus.MEM_LoadType  = lt;
    bus.MEM_RegWrite  = rw;
    bus.MEM_WriteReg  = rd;
    bus.MEM_ALUResult = alu;
  endtask

  task automatic expect_wr(input string tag, input logic v,
                           input logic rw, input logic [4:0] rd,
                           input logic [31:0] d);
    check({tag, "_stall"}, {31'd0, bus.WB_Stall}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.WB_Valid}, {31'd0, v});
    check({tag, "_rw"}, {31'd0, bus.WB_RegWrite}, {31'd0, rw});
    check({tag, "_reg"}, {27'd0, bus.WB_WriteReg}, {27'd0, rd});
    check({tag, "_data"}, bus.WB_WriteData, d);
  endtask

  task automatic load(input string tag, input logic [2:0] lt,
                      input logic rw, input logic [31:0] addr,
                      input logic [31:0] ld, input int waitc,
                      input logic [31:0] exp);
    issue(2'd1, lt, rw, 5'd7, addr);
    step();
    bus.MEM_Valid = 1'b0;
    check({tag, "_lwait_stall"}, {31'd0, bus.WB_Stall}, 32'd1);
    check({tag, "_lwait_valid"}, {31'd0, bus.WB_Valid}, 32'd0);
    for (int i = 1; i < waitc; i++) begin
      step();
      check({tag, "_hold_stall"}, {31'd0, bus.WB_Stall}, 32'd1);
    end
    bus.LD_Valid = 1'b1;
    bus.LD_Data  = ld;
    step();
    bus.LD_Valid = 1'b0;
    expect_wr(tag, 1'b1, rw, 5'd7, exp);
  endtask

  initial begin
    bus.MEM_LinkAddr = 32'h0000_0400;
    bus.MEM_HiLo     = 32'h0;
    bus.LD_Data      = 32'h0;
    bus.LD_Valid     = 1'b0;
    issue(2'd0, 3'd0, 1'b1, 5'd5, 32'h99);

    // reset with a valid instruction waiting
    Reset = 1'b1;
    step();
    step();
    expect_wr("rst", 1'b0, 1'b0, 5'd0, 32'h0);
    Reset = 1'b0;
    #1;
    expect_wr("rst_low", 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    expect_wr("first", 1'b1, 1'b1, 5'd5, 32'h99);

    // back-to-back ALU writes
    issue(2'd0, 3'd0, 1'b1, 5'd3, 32'h11);
    step();
    expect_wr("alu0", 1'b1, 1'b1, 5'd3, 32'h11);
    issue(2'd0, 3'd0, 1'b1, 5'd4, 32'h22);
    step();
    expect_wr("alu1", 1'b1, 1'b1, 5'd4, 32'h22);
    bus.MEM_Valid = 1'b0;
    step();
    expect_wr("idle", 1'b0, 1'b0, 5'd0, 32'h0);

    // HI/LO source
    bus.MEM_HiLo = 32'hCAFE_0001;
    issue(2'd3, 3'd0, 1'b1, 5'd9, 32'h5);
    step();
    bus.MEM_Valid = 1'b0;
    expect_wr("hilo", 1'b1, 1'b1, 5'd9, 32'hCAFE_0001);

    // stray LD_Valid outside LWAIT
    bus.LD_Valid = 1'b1;
    step();
    bus.LD_Valid = 1'b0;
    expect_wr("ldstray", 1'b0, 1'b0, 5'd0, 32'h0);

    // load extraction
    load("lb", 3'd3, 1'b1, 32'h1002, 32'h1280_3456, 1, 32'hFFFF_FF80);
    load("lbu", 3'd4, 1'b1, 32'h1002, 32'h1280_3456, 1, 32'h0000_0080);
    load("lh", 3'd1, 1'b1, 32'h1002, 32'h8001_1234, 1, 32'hFFFF_8001);
    load("lhu", 3'd2, 1'b1, 32'h1000, 32'h8001_1234, 1, 32'h0000_1234);
    load("lb0", 3'd3, 1'b1, 32'h1000, 32'h1280_3456, 1, 32'h0000_0056);
    load("lw7", 3'd7, 1'b1, 32'h1003, 32'h8765_4321, 2, 32'h8765_4321);
    load("lwnorw", 3'd0, 1'b0, 32'h1000, 32'h0000_00AA, 1, 32'h0000_00AA);
    bus.MEM_Valid = 1'b0;
    step();
    expect_wr("ldidle", 1'b0, 1'b0, 5'd0, 32'h0);

    // slow memory with the next instruction held during the stall
    issue(2'd1, 3'd0, 1'b1, 5'd8, 32'h2000);
    step();
    issue(2'd0, 3'd0, 1'b1, 5'd10, 32'h55);
    for (int i = 0; i < 3; i++) begin
      check("slow_stall", {31'd0, bus.WB_Stall}, 32'd1);
      check("slow_valid", {31'd0, bus.WB_Valid}, 32'd0);
      if (i < 2) step();
    end
    bus.LD_Valid = 1'b1;
    bus.LD_Data  = 32'hDEAD_BEEF;
    step();
    bus.LD_Valid = 1'b0;
    expect_wr("slow_ld", 1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF);
    step();
    bus.MEM_Valid = 1'b0;
    expect_wr("slow_held", 1'b1, 1'b1, 5'd10, 32'h55);
    step();
    expect_wr("slow_once", 1'b0, 1'b0, 5'd0, 32'h0);

    // link to r0 is suppressed, link to r31 is written
    issue(2'd2, 3'd0, 1'b1, 5'd0, 32'h0);
    step();
    expect_wr("link_r0", 1'b1, 1'b0, 5'd0, 32'h400);
    issue(2'd2, 3'd0, 1'b1, 5'd31, 32'h0);
    step();
    bus.MEM_Valid = 1'b0;
    expect_wr("link_r31", 1'b1, 1'b1, 5'd31, 32'h400);

    // reset while a load is outstanding
    issue(2'd1, 3'd0, 1'b1, 5'd12, 32'h3000);
    step();
    bus.MEM_Valid = 1'b0;
    check("rl_stall", {31'd0, bus.WB_Stall}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    expect_wr("rl_rst", 1'b0, 1'b0, 5'd0, 32'h0);
    bus.LD_Valid = 1'b1;
    bus.LD_Data  = 32'h1234_5678;
    step();
    bus.LD_Valid = 1'b0;
    expect_wr("rl_after", 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    expect_wr("rl_empty", 1'b0, 1'b0, 5'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
